inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction-word writer for the DLX datapath: the inverse of the control decoder. Accepts field-level instruction requests (format, opcode, func, registers, immediate), packs them into 32-bit DLX words, and streams them with sequential addresses into instruction memory through a buffered valid/ready port. Used by the program loader and test harness to build instruction images. Stops on TRAP until restarted.

## Interface
- ADDR_W, 10, instruction address width (word addresses).
- FIFO_DEPTH, 4, output buffer entries; power of 2, at least 2.
- RESET_ADDR, 0, address counter value after reset.

- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_fmt  in  2  0=R, 1=I, 2=J, 3=illegal
- in_opcode  in  6  opcode; ignored for R (forced 0)
- in_func  in  6  R-type func code
- in_rs1, in_rs2, in_rd  in  5 each  register fields
- in_imm  in  26  immediate (I uses [15:0] after range check, J uses all)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  memory accepts head
- out_word  out  32  head instruction word
- out_addr  out  ADDR_W  address for head word
- addr_load  in  1  load address counter (HALTED only)
- addr_val  in  ADDR_W  value for addr_load
- restart  in  1  leave HALTED
- halted  out  1  state == HALTED
- err_cnt  out  8  dropped-request count, saturating at 255

## Operation
- Encoding. R: {6'h0, rs1, rs2, rd, 5'h0, func}. I: {opcode, rs1, rd, imm[15:0]}. J: {opcode, imm[25:0]}.
- I-range check: zero-extended opcodes (09, 0b, 0c, 0d, 0e, 0f) need imm[25:16]==0. All other I opcodes need imm[25:15] all equal.
- Dropped requests: a failing range check or in_fmt==3 still handshakes. No word is pushed and err_cnt increments. An illegal TRAP does not change state.
- Accepted legal words are pushed into the FIFO. On each out handshake the head pops and the address counter increments. The counter wraps modulo 2^ADDR_W. out_addr always shows the counter.
- FSM states RUN, DRAIN, HALTED.
  - RUN: in_ready = (count < FIFO_DEPTH). Accepting a legal J-format word with opcode 6'h11 (TRAP) pushes it and moves to DRAIN.
  - DRAIN: in_ready = 0. Moves to HALTED on the cycle the FIFO becomes empty.
  - HALTED: in_ready = 0 and halted = 1. addr_load loads addr_val. restart moves to RUN. If both are asserted in the same cycle, the load takes effect and the state moves to RUN.
- addr_load and restart are ignored outside HALTED.

## Timing
- Reset values:
  - state RUN, count 0, address RESET_ADDR
  - out_valid 0, out_word 0 (storage cleared), halted 0, err_cnt 0
  - in_ready 1 once rst deasserts
- Latency: a word accepted in cycle N appears at out_valid in cycle N+1. There is no combinational input-to-output path.
- in_ready does not depend on out_ready. When the FIFO is full, a simultaneous pop does not open the input that cycle.
- Simultaneous push and pop with a non-empty FIFO: count is unchanged and order is preserved.
- out_valid is held, and out_word and out_addr are stable, until out_ready.
- Asserting rst mid-stream empties the FIFO immediately and returns all outputs to their reset values.
- err_cnt updates one cycle after the dropped handshake.

## Test plan
- R ADD (fmt 0, func 0x20, rs1=1, rs2=2, rd=3) after reset, out_ready=1 -> out_word 0x00221820, out_addr 0 in the next cycle.
- ADDI (fmt 1, opcode 0x08, rs1=1, rd=2, imm 0x3FFFFFF) -> 0x2022FFFF. ORI with imm 0x0010000 -> no word, err_cnt=1, address unchanged.
- out_ready=0, send 5 legal words -> in_ready low after the 4th accept. Then out_ready=1 -> 4 words at addresses 0..3, in order, and in_ready recovers.
- J (opcode 0x02, imm 0x100) then TRAP (opcode 0x11) -> 0x08000100, 0x44000000. halted=1 the cycle after the last pop, and in_ready=0.
- In HALTED, assert addr_load=1 with addr_val=0x3FF and restart=1. Send 2 words -> addresses 0x3FF then 0x000 (wrap).
- Assert rst with 3 words queued -> out_valid=0, err_cnt=0, out_addr=RESET_ADDR, with no pops after release.

Source files
------------

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Packs field-level DLX instruction requests (format, opcode, func, register
// fields, immediate) into 32-bit instruction words and streams them, with
// sequential word addresses, into instruction memory through a small output
// FIFO. A legal TRAP drains the FIFO and parks the block in HALTED until a
// restart. While halted the address counter can be reloaded.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_fmt              0=R, 1=I, 2=J, 3=illegal
//   in_opcode, in_func  opcode (unused for R) and R-type function code
//   in_rs1/rs2/rd       register fields
//   in_imm              26-bit immediate (I uses [15:0], J uses all)
//   out_valid/out_ready output handshake toward instruction memory
//   out_word, out_addr  FIFO head word and the address it is written to
//   addr_load, addr_val reload of the address counter (HALTED only)
//   restart             leave HALTED
//   halted              high while in HALTED
//   err_cnt             saturating count of dropped requests
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_func,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,

    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_val,
    input  logic              restart,
    output logic              halted,
    output logic [7:0]        err_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] OP_TRAP = 6'h11;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_q, err_d;

    logic [31:0] word;
    logic        legal;
    logic        zext_op;
    logic        imm_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        is_trap;

    // ------------------------------------------------------------------
    // Field packing and I-type immediate range check
    // ------------------------------------------------------------------
    // Logical/unsigned I opcodes take a zero-extended 16-bit immediate,
    // everything else a sign-extended one, so the bits above the field
    // must be a plain extension of it.
    assign zext_op = (in_opcode == 6'h09) || (in_opcode == 6'h0b) ||
                     (in_opcode == 6'h0c) || (in_opcode == 6'h0d) ||
                     (in_opcode == 6'h0e) || (in_opcode == 6'h0f);

    assign imm_ok = zext_op ? (in_imm[25:16] == '0)
                            : ((in_imm[25:15] == '0) || (in_imm[25:15] == '1));

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt_e'(in_fmt))
            FMT_R: begin
                word  = {6'h00, in_rs1, in_rs2, in_rd, 5'h00, in_func};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {in_opcode, in_rs1, in_rd, in_imm[15:0]};
                legal = imm_ok;
            end
            FMT_J: begin
                word  = {in_opcode, in_imm};
                legal = 1'b1;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // in_ready is a function of registered state only; a pop from a full
    // FIFO does not open the input in the same cycle.
    assign in_ready  = (state_q == ST_RUN) && (count_q < CNT_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign is_trap   = (fmt_e'(in_fmt) == FMT_J) && (in_opcode == OP_TRAP);

    assign out_word  = mem_q[rd_ptr_q];
    assign out_addr  = addr_q;
    assign halted    = (state_q == ST_HALTED);
    assign err_cnt   = err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        err_d   = err_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (accept && !legal && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end

        case (state_q)
            ST_RUN: begin
                if (push && is_trap) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // The FIFO is empty here, so a load never races a pop.
                if (addr_load) begin
                    addr_d = addr_val;
                end
                if (restart) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
            addr_q  <= ADDR_W'(RESET_ADDR);
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array is reset on purpose: out_word is the head
    // entry and must read zero after reset, not stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= word;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [5:0]        in_opcode;
    logic [5:0]        in_func;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic [25:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_val;
    logic              restart;
    logic              halted;
    logic [7:0]        err_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_err;

    inst_encoder #(
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(4),
        .RESET_ADDR(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_fmt   (in_fmt),
        .in_opcode(in_opcode),
        .in_func  (in_func),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_rd    (in_rd),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_addr (out_addr),
        .addr_load(addr_load),
        .addr_val (addr_val),
        .restart  (restart),
        .halted   (halted),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: at each negedge where the head will be taken on the next
    // rising edge, compare it with the oldest expected word and address.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", out_word, 32'hDEAD_BEEF);
            end else begin
                chk("pop_word", out_word, exp_q[0]);
                chk("pop_addr", {22'h0, out_addr}, {22'h0, exp_addr});
                void'(exp_q.pop_front());
                exp_addr = exp_addr + 10'd1;
            end
        end
    end

    // Drives one request and holds it until accepted (bounded).
    task automatic send(input logic [1:0] fmt, input logic [5:0] op,
                        input logic [5:0] func, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [25:0] imm, input bit legal,
                        input logic [31:0] word);
        in_fmt    = fmt;
        in_opcode = op;
        in_func   = func;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) break;
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            if (legal) exp_q.push_back(word);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_r(input logic [5:0] func, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd);
        send(2'd0, 6'h3F, func, rs1, rs2, rd, 26'h0,
             1'b1, {6'h00, rs1, rs2, rd, 5'h00, func});
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
        chk("drain_done", {31'h0, out_valid}, 32'd0);
        chk("drain_queue", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fmt    = '0;
        in_opcode = '0;
        in_func   = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_imm    = '0;
        out_ready = 1'b0;
        addr_load = 1'b0;
        addr_val  = '0;
        restart   = 1'b0;
        exp_addr  = '0;
        exp_err   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_addr", {22'h0, out_addr}, 32'd0);
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);

        // R ADD, one-cycle latency to out_valid
        out_ready = 1'b1;
        send(2'd0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 32'h0022_1820);
        chk("radd_valid", {31'h0, out_valid}, 32'd1);
        chk("radd_word", out_word, 32'h0022_1820);
        chk("radd_addr", {22'h0, out_addr}, 32'd0);

        // ADDI with sign-extended all-ones immediate
        send(2'd1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd2, 26'h3FF_FFFF, 1'b1, 32'h2022_FFFF);

        // ORI out of zero-extended range: dropped
        send(2'd1, 6'h0d, 6'h00, 5'd1, 5'd0, 5'd2, 26'h001_0000, 1'b0, 32'h0);
        exp_err = exp_err + 8'd1;
        chk("ori_err_cnt", {24'h0, err_cnt}, {24'h0, exp_err});
        wait_empty();
        chk("ori_addr", {22'h0, out_addr}, 32'd2);

        // Illegal format with TRAP opcode: dropped, stays in RUN
        send(2'd3, 6'h11, 6'h00, 5'd0, 5'd0, 5'd0, 26'h0, 1'b0, 32'h0);
        exp_err = exp_err + 8'd1;
        chk("badfmt_err_cnt", {24'h0, err_cnt}, {24'h0, exp_err});
        chk("badfmt_in_ready", {31'h0, in_ready}, 32'd1);
        chk("badfmt_halted", {31'h0, halted}, 32'd0);

        // addr_load / restart ignored in RUN
        addr_load = 1'b1;
        addr_val  = 10'h155;
        restart   = 1'b1;
        @(posedge clk); #1;
        addr_load = 1'b0;
        restart   = 1'b0;
        chk("run_load_ignored", {22'h0, out_addr}, {22'h0, exp_addr});

        // Back-pressure: fill the FIFO, then release
        out_ready = 1'b0;
        send_r(6'h20, 5'd4, 5'd5, 5'd6);
        send_r(6'h22, 5'd7, 5'd8, 5'd9);
        send_r(6'h24, 5'd10, 5'd11, 5'd12);
        send_r(6'h25, 5'd13, 5'd14, 5'd15);
        chk("full_in_ready", {31'h0, in_ready}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'h0, out_valid}, 32'd1);
            chk("stall_word", out_word, exp_q[0]);
            chk("stall_addr", {22'h0, out_addr}, {22'h0, exp_addr});
        end
        out_ready = 1'b1;
        chk("full_pop_in_ready", {31'h0, in_ready}, 32'd0);
        send_r(6'h26, 5'd16, 5'd17, 5'd18);
        wait_empty();
        chk("recover_in_ready", {31'h0, in_ready}, 32'd1);

        // J then TRAP, drain to HALTED
        send(2'd2, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 26'h000_0100, 1'b1, 32'h0800_0100);
        send(2'd2, 6'h11, 6'h00, 5'd0, 5'd0, 5'd0, 26'h000_0000, 1'b1, 32'h4400_0000);
        chk("drain_in_ready", {31'h0, in_ready}, 32'd0);
        chk("drain_halted", {31'h0, halted}, 32'd0);
        @(posedge clk); #1;
        chk("halt_halted", {31'h0, halted}, 32'd1);
        chk("halt_in_ready", {31'h0, in_ready}, 32'd0);
        chk("halt_out_valid", {31'h0, out_valid}, 32'd0);
        chk("halt_queue", exp_q.size(), 32'd0);

        // Load 0x3FF and restart together, then wrap
        addr_load = 1'b1;
        addr_val  = 10'h3FF;
        restart   = 1'b1;
        @(posedge clk); #1;
        addr_load = 1'b0;
        restart   = 1'b0;
        exp_addr  = 10'h3FF;
        chk("restart_halted", {31'h0, halted}, 32'd0);
        chk("restart_addr", {22'h0, out_addr}, 32'h3FF);
        chk("restart_in_ready", {31'h0, in_ready}, 32'd1);
        send_r(6'h20, 5'd1, 5'd1, 5'd1);
        send_r(6'h21, 5'd2, 5'd2, 5'd2);
        wait_empty();
        chk("wrap_addr", {22'h0, out_addr}, 32'h001);

        // Reset with words queued
        out_ready = 1'b0;
        send_r(6'h2a, 5'd3, 5'd4, 5'd5);
        send_r(6'h2b, 5'd6, 5'd7, 5'd8);
        send_r(6'h2c, 5'd9, 5'd10, 5'd11);
        chk("pre_rst_valid", {31'h0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_addr = '0;
        exp_err  = '0;
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("mid_rst_err_cnt", {24'h0, err_cnt}, 32'd0);
        chk("mid_rst_out_addr", {22'h0, out_addr}, 32'd0);
        chk("mid_rst_out_word", out_word, 32'd0);
        chk("mid_rst_halted", {31'h0, halted}, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("post_rst_no_pop", {31'h0, out_valid}, 32'd0);
        end
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("post_rst_addr", {22'h0, out_addr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
